// File: rtl/key_display_scan_if.sv
// -----------------------------------------------------------------------------
// key_display_scan_if
// Bundles the signals between the keypad scanner / test driver and the
// multiplexed 7-segment display driver.
//
//   code_in     4       key code from the scanner
//   code_valid  1       one-cycle strobe qualifying code_in
//   seg         7       segment pattern, active-high, bit6=a .. bit0=g
//   digit_sel   DIGITS  one-hot digit enable, bit0 = rightmost digit
//   fill        3       number of non-blank digits held in the buffer
//
// master: code producer / display consumer side
// slave : key_display_scan side
// -----------------------------------------------------------------------------
interface key_display_scan_if #(
  parameter int DIGITS = 4
);
  logic [3:0]        code_in;
  logic              code_valid;
  logic [6:0]        seg;
  logic [DIGITS-1:0] digit_sel;
  logic [2:0]        fill;

  modport master (
    output code_in,
    output code_valid,
    input  seg,
    input  digit_sel,
    input  fill
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output seg,
    output digit_sel,
    output fill
  );
endinterface

// File: rtl/key_display_scan.sv
// -----------------------------------------------------------------------------
// key_display_scan
// Keeps a shift buffer of the last DIGITS key codes entered on the keypad,
// decodes them to 7-segment patterns and time-multiplexes them onto a shared
// segment bus.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   key_display_scan_if.slave
//           code_in/code_valid  key codes from the scanner
//           seg/digit_sel       multiplexed display drive (registered)
//           fill                count of non-blank digits (saturates at DIGITS)
//
// Parameters:
//   DIGITS       display positions, 2..7
//   REFRESH_DIV  cycles each digit stays selected, >= 2
// -----------------------------------------------------------------------------
module key_display_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  key_display_scan_if.slave     bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       FILL_MAX = 3'(DIGITS);

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_CLEAR = 4'd11;

  // Buffer: entry 0 is the most recently entered code (rightmost digit).
  logic [3:0]        buf_code_q [DIGITS];
  logic [DIGITS-1:0] buf_vld_q;
  logic [2:0]        fill_q;

  logic [DIV_W-1:0]  div_q;
  logic [IDX_W-1:0]  idx_q;

  logic [6:0]        seg_q;
  logic [DIGITS-1:0] digit_sel_q;

  logic [3:0]        buf_code_nxt [DIGITS];
  logic [DIGITS-1:0] buf_vld_nxt;
  logic [2:0]        fill_nxt;
  logic              div_tc;
  logic [DIV_W-1:0]  div_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DIGITS-1:0] sel_nxt;
  logic [6:0]        seg_nxt;

  function automatic logic [6:0] decode_seg(input logic [3:0] code, input logic vld);
    logic [6:0] pat;
    pat = 7'b0000000;
    if (vld) begin
      case (code)
        4'd0:    pat = 7'b1111110;
        4'd1:    pat = 7'b0110000;
        4'd2:    pat = 7'b1101101;
        4'd3:    pat = 7'b1111001;
        4'd4:    pat = 7'b0110011;
        4'd5:    pat = 7'b1011011;
        4'd6:    pat = 7'b1011111;
        4'd7:    pat = 7'b1110000;
        4'd8:    pat = 7'b1111111;
        4'd9:    pat = 7'b1111011;
        4'd10:   pat = 7'b0000001;
        default: pat = 7'b0000000;
      endcase
    end
    return pat;
  endfunction

  // Buffer update from a code strobe.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      buf_code_nxt[i] = buf_code_q[i];
    end
    buf_vld_nxt = buf_vld_q;
    fill_nxt    = fill_q;

    if (bus.code_valid) begin
      if (bus.code_in <= CODE_DASH) begin
        for (int i = DIGITS - 1; i > 0; i--) begin
          buf_code_nxt[i] = buf_code_q[i-1];
          buf_vld_nxt[i]  = buf_vld_q[i-1];
        end
        buf_code_nxt[0] = bus.code_in;
        buf_vld_nxt[0]  = 1'b1;
        if (fill_q != FILL_MAX) begin
          fill_nxt = fill_q + 3'd1;
        end
      end else if (bus.code_in == CODE_CLEAR) begin
        for (int i = 0; i < DIGITS; i++) begin
          buf_code_nxt[i] = 4'd0;
        end
        buf_vld_nxt = '0;
        fill_nxt    = 3'd0;
      end
    end
  end

  // Refresh divider and digit index; independent of code traffic.
  always_comb begin
    div_tc  = (div_q == DIV_LAST);
    div_nxt = div_tc ? '0 : div_q + DIV_W'(1);
    idx_nxt = idx_q;
    if (div_tc) begin
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    sel_nxt          = '0;
    sel_nxt[idx_nxt] = 1'b1;
    // The segment register is loaded together with digit_sel so both always
    // refer to the same digit. It reads the buffer as it stands before this
    // edge, so a strobe becomes visible on seg one edge after it is taken.
    seg_nxt = decode_seg(buf_code_q[idx_nxt], buf_vld_q[idx_nxt]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        buf_code_q[i] <= 4'd0;
      end
      buf_vld_q   <= '0;
      fill_q      <= 3'd0;
      div_q       <= '0;
      idx_q       <= '0;
      seg_q       <= 7'b0000000;
      digit_sel_q <= DIGITS'(1);
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        buf_code_q[i] <= buf_code_nxt[i];
      end
      buf_vld_q   <= buf_vld_nxt;
      fill_q      <= fill_nxt;
      div_q       <= div_nxt;
      idx_q       <= idx_nxt;
      seg_q       <= seg_nxt;
      digit_sel_q <= sel_nxt;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.digit_sel = digit_sel_q;
  assign bus.fill      = fill_q;

endmodule
